execution_mdu: RTL and testbench

//  EX stage of the 5-stage MIPS pipeline: ALU path with MA/WB forwarding, plus an iterative

---
 rtl/execution_mdu_if.sv | 56 +++++
 rtl/execution_mdu.sv | 241 ++++++++++++++++++++++++
 tb/tb_execution_mdu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/execution_mdu_if.sv
// EX-stage bundle: ID/EX inputs, forwarding sources and EX/MA outputs of execution_mdu.
// Optional feature of the attached block: EXECUTION_FAST_MUL_EN (single-cycle multiply).
interface execution_mdu_if #(
  parameter int unsigned NB_DATA           = 32,
  parameter int unsigned NB_ALU_OP         = 6,
  parameter int unsigned NB_ADDR_REGISTERS = 5,
  parameter int unsigned NB_CONTROL_EX     = 5,
  parameter int unsigned NB_CONTROL_MA_WB  = 7
) ();
  localparam int unsigned NB_CONTROL = NB_CONTROL_EX + NB_CONTROL_MA_WB;

  logic                         i_clk_en;
  logic [NB_CONTROL-1:0]        i_control_bus;
  logic [NB_DATA-1:0]           i_bus_a;
  logic [NB_DATA-1:0]           i_bus_b;
  logic [NB_DATA-1:0]           i_ext_literal;
  logic [NB_DATA-1:0]           i_ext_sa;
  logic [NB_DATA-1:0]           i_pc_delay_slot;
  logic [NB_ALU_OP-1:0]         i_alu_op;
  logic [3:0]                   i_mdu_op;
  logic [NB_ADDR_REGISTERS-1:0] i_id_rs_num;
  logic [NB_ADDR_REGISTERS-1:0] i_id_rt_num;
  logic [NB_ADDR_REGISTERS-1:0] i_id_rd_num;
  logic [NB_DATA-1:0]           i_ma_rd_data;
  logic [NB_ADDR_REGISTERS-1:0] i_ma_rd_num;
  logic                         i_ma_ctl_rw;
  logic [NB_DATA-1:0]           i_wb_rd_data;
  logic [NB_ADDR_REGISTERS-1:0] i_wb_rd_num;
  logic                         i_wb_ctl_rw;
  logic [NB_CONTROL_MA_WB-1:0]  o_control_ma_wb;
  logic [NB_DATA-1:0]           o_result;
  logic [NB_DATA-1:0]           o_w_data_mem;
  logic [NB_ADDR_REGISTERS-1:0] o_rd_num;
  logic [NB_ADDR_REGISTERS-1:0] o_id_rd_num;
  logic                         o_id_ctl_mem_read;
  logic                         o_id_ctl_reg_write;
  logic [NB_DATA-1:0]           o_id_alu_result;
  logic                         o_stall;
  logic                         o_mdu_busy;

  modport master (
    output i_clk_en, i_control_bus, i_bus_a, i_bus_b, i_ext_literal, i_ext_sa, i_pc_delay_slot,
           i_alu_op, i_mdu_op, i_id_rs_num, i_id_rt_num, i_id_rd_num,
           i_ma_rd_data, i_ma_rd_num, i_ma_ctl_rw, i_wb_rd_data, i_wb_rd_num, i_wb_ctl_rw,
    input  o_control_ma_wb, o_result, o_w_data_mem, o_rd_num, o_id_rd_num,
           o_id_ctl_mem_read, o_id_ctl_reg_write, o_id_alu_result, o_stall, o_mdu_busy
  );

  modport slave (
    input  i_clk_en, i_control_bus, i_bus_a, i_bus_b, i_ext_literal, i_ext_sa, i_pc_delay_slot,
           i_alu_op, i_mdu_op, i_id_rs_num, i_id_rt_num, i_id_rd_num,
           i_ma_rd_data, i_ma_rd_num, i_ma_ctl_rw, i_wb_rd_data, i_wb_rd_num, i_wb_ctl_rw,
    output o_control_ma_wb, o_result, o_w_data_mem, o_rd_num, o_id_rd_num,
           o_id_ctl_mem_read, o_id_ctl_reg_write, o_id_alu_result, o_stall, o_mdu_busy
  );
endinterface

// File: rtl/execution_mdu.sv
// EX stage: ALU with MA/WB forwarding plus an iterative multiply/divide unit owning HI/LO.
// Define EXECUTION_FAST_MUL_EN for a single-cycle combinational MULT/MULTU.
module execution_mdu #(
  parameter int unsigned NB_DATA           = 32,
  parameter int unsigned NB_ALU_OP         = 6,
  parameter int unsigned NB_ADDR_REGISTERS = 5,
  parameter int unsigned NB_CONTROL_EX     = 5,
  parameter int unsigned NB_CONTROL_MA_WB  = 7
) (
  input logic             i_clk,
  input logic             i_reset,
  execution_mdu_if.slave  bus
);
  localparam int unsigned NB_CONTROL = NB_CONTROL_EX + NB_CONTROL_MA_WB;
  localparam int unsigned NB_SHAMT   = $clog2(NB_DATA);
  localparam int unsigned NB_CNT     = $clog2(NB_DATA);

  localparam logic [NB_ALU_OP-1:0] ALU_SLL  = NB_ALU_OP'('h00), ALU_SRL  = NB_ALU_OP'('h02),
                                   ALU_SRA  = NB_ALU_OP'('h03), ALU_SLLV = NB_ALU_OP'('h04),
                                   ALU_SRLV = NB_ALU_OP'('h06), ALU_SRAV = NB_ALU_OP'('h07),
                                   ALU_LUI  = NB_ALU_OP'('h0f), ALU_ADD  = NB_ALU_OP'('h20),
                                   ALU_ADDU = NB_ALU_OP'('h21), ALU_SUB  = NB_ALU_OP'('h22),
                                   ALU_SUBU = NB_ALU_OP'('h23), ALU_AND  = NB_ALU_OP'('h24),
                                   ALU_OR   = NB_ALU_OP'('h25), ALU_XOR  = NB_ALU_OP'('h26),
                                   ALU_NOR  = NB_ALU_OP'('h27), ALU_SLT  = NB_ALU_OP'('h2a),
                                   ALU_SLTU = NB_ALU_OP'('h2b);

  localparam logic [3:0] MDU_MULT = 4'd1, MDU_MULTU = 4'd2, MDU_DIV = 4'd3, MDU_DIVU = 4'd4,
                         MDU_MFHI = 4'd5, MDU_MFLO  = 4'd6, MDU_MTHI = 4'd7, MDU_MTLO = 4'd8;

  localparam logic [2:0] S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2, S_FIX_MUL = 3'd3, S_FIX_DIV = 3'd4;

  logic                         ctl_reg_dest, ctl_rs_sa, ctl_rt_imm, ctl_use_pc, ctl_reg_dest_31;
  logic [NB_CONTROL_MA_WB-1:0]  ctl_ma_wb;
  logic [NB_DATA-1:0]           rs_data, rt_data, alu_a, alu_b, alu_result, ex_result;
  logic [NB_SHAMT-1:0]          shamt;
  logic [NB_ADDR_REGISTERS-1:0] dest_num;
  logic                         op_mul, op_div, op_signed, no_gpr, reg_write;
  logic                         stall, advance, start_mul, start_div, sign_a, sign_b;
  logic [NB_DATA-1:0]           abs_a, abs_b;

  logic [2:0]                   state, state_next;
  logic [NB_CNT-1:0]            cnt, cnt_next;
  logic [2*NB_DATA-1:0]         acc, acc_next;
  logic [NB_DATA-1:0]           opnd, opnd_next, hi, hi_next, lo, lo_next;
  logic                         neg_hi, neg_hi_next, neg_lo, neg_lo_next;
  logic [NB_DATA:0]             mul_sum, div_shift;
  logic [NB_DATA+1:0]           div_diff;

  logic [NB_CONTROL_MA_WB-1:0]  ctl_q;
  logic [NB_DATA-1:0]           result_q, wdata_q;
  logic [NB_ADDR_REGISTERS-1:0] rd_q;
  logic                         busy_q;

  assign {ctl_reg_dest, ctl_rs_sa, ctl_rt_imm, ctl_use_pc, ctl_reg_dest_31} =
    bus.i_control_bus[NB_CONTROL-1 -: 5];
  assign ctl_ma_wb = bus.i_control_bus[NB_CONTROL_MA_WB-1:0];

  // Operand forwarding: MA has priority over WB, register 0 is never forwarded
  always_comb begin
    rs_data = bus.i_bus_a;
    rt_data = bus.i_bus_b;
    if (bus.i_id_rs_num != '0 && bus.i_ma_ctl_rw && bus.i_ma_rd_num == bus.i_id_rs_num)
      rs_data = bus.i_ma_rd_data;
    else if (bus.i_id_rs_num != '0 && bus.i_wb_ctl_rw && bus.i_wb_rd_num == bus.i_id_rs_num)
      rs_data = bus.i_wb_rd_data;
    if (bus.i_id_rt_num != '0 && bus.i_ma_ctl_rw && bus.i_ma_rd_num == bus.i_id_rt_num)
      rt_data = bus.i_ma_rd_data;
    else if (bus.i_id_rt_num != '0 && bus.i_wb_ctl_rw && bus.i_wb_rd_num == bus.i_id_rt_num)
      rt_data = bus.i_wb_rd_data;
  end

  assign op_mul    = (bus.i_mdu_op == MDU_MULT) || (bus.i_mdu_op == MDU_MULTU);
  assign op_div    = (bus.i_mdu_op == MDU_DIV)  || (bus.i_mdu_op == MDU_DIVU);
  assign op_signed = (bus.i_mdu_op == MDU_MULT) || (bus.i_mdu_op == MDU_DIV);
  assign no_gpr    = op_mul || op_div || (bus.i_mdu_op == MDU_MTHI) || (bus.i_mdu_op == MDU_MTLO);
  assign dest_num  = ctl_reg_dest_31 ? '1 : (ctl_reg_dest ? bus.i_id_rd_num : bus.i_id_rt_num);
  assign reg_write = ctl_ma_wb[0] && (dest_num != '0) && !no_gpr;

  assign alu_a = ctl_use_pc ? bus.i_pc_delay_slot : (ctl_rs_sa ? bus.i_ext_sa : rs_data);
  assign alu_b = ctl_rt_imm ? bus.i_ext_literal : rt_data;
  assign shamt = alu_a[NB_SHAMT-1:0];

  // ALU; variable and immediate shifts differ only in where alu_a comes from
  always_comb begin
    alu_result = '0;
    case (bus.i_alu_op)
      ALU_SLL, ALU_SLLV: alu_result = alu_b << shamt;
      ALU_SRL, ALU_SRLV: alu_result = alu_b >> shamt;
      ALU_SRA, ALU_SRAV: alu_result = $signed(alu_b) >>> shamt;
      ALU_LUI:           alu_result = alu_b << (NB_DATA / 2);
      ALU_ADD, ALU_ADDU: alu_result = alu_a + alu_b;
      ALU_SUB, ALU_SUBU: alu_result = alu_a - alu_b;
      ALU_AND:           alu_result = alu_a & alu_b;
      ALU_OR:            alu_result = alu_a | alu_b;
      ALU_XOR:           alu_result = alu_a ^ alu_b;
      ALU_NOR:           alu_result = ~(alu_a | alu_b);
      ALU_SLT:           alu_result = NB_DATA'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU:          alu_result = NB_DATA'(alu_a < alu_b);
      default:           alu_result = '0;
    endcase
  end

  assign ex_result = (bus.i_mdu_op == MDU_MFHI) ? hi :
                     (bus.i_mdu_op == MDU_MFLO) ? lo : alu_result;

  assign stall     = (state != S_IDLE) && (bus.i_mdu_op >= MDU_MULT) && (bus.i_mdu_op <= MDU_MTLO);
  assign advance   = bus.i_clk_en && !stall;
  assign sign_a    = op_signed && rs_data[NB_DATA-1];
  assign sign_b    = op_signed && rt_data[NB_DATA-1];
  assign abs_a     = sign_a ? -rs_data : rs_data;
  assign abs_b     = sign_b ? -rt_data : rt_data;
  assign start_div = advance && op_div;
`ifdef EXECUTION_FAST_MUL_EN
  logic [2*NB_DATA-1:0] fast_prod;
  assign start_mul = 1'b0;
  // Sign/zero-extended operands: the low 2*NB_DATA bits are the exact product
  assign fast_prod = op_signed ?
    ({{NB_DATA{rs_data[NB_DATA-1]}}, rs_data} * {{NB_DATA{rt_data[NB_DATA-1]}}, rt_data}) :
    ({{NB_DATA{1'b0}}, rs_data} * {{NB_DATA{1'b0}}, rt_data});
`else
  assign start_mul = advance && op_mul;
`endif

  // acc holds {partial product} for MUL and {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};

  // MDU next-state and datapath; divide by zero naturally yields rem=dividend, quo=all ones
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    acc_next    = acc;
    opnd_next   = opnd;
    neg_hi_next = neg_hi;
    neg_lo_next = neg_lo;
    hi_next     = hi;
    lo_next     = lo;
    case (state)
      S_IDLE: begin
        if (start_mul) begin
          state_next  = S_MUL;
          cnt_next    = '0;
          acc_next    = {{NB_DATA{1'b0}}, abs_b};
          opnd_next   = abs_a;
          neg_hi_next = sign_a ^ sign_b;
        end else if (start_div) begin
          state_next  = S_DIV;
          cnt_next    = '0;
          acc_next    = {{NB_DATA{1'b0}}, abs_a};
          opnd_next   = abs_b;
          neg_hi_next = sign_a;
          neg_lo_next = (sign_a ^ sign_b) && (rt_data != '0);
        end
      end
      S_MUL: begin
        acc_next = {mul_sum, acc[NB_DATA-1:1]};
        cnt_next = cnt + 1'b1;
        if (cnt == NB_CNT'(NB_DATA - 1)) state_next = S_FIX_MUL;
      end
      S_DIV: begin
        if (!div_diff[NB_DATA+1]) acc_next = {div_diff[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1};
        else                      acc_next = {div_shift[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0};
        cnt_next = cnt + 1'b1;
        if (cnt == NB_CNT'(NB_DATA - 1)) state_next = S_FIX_DIV;
      end
      S_FIX_MUL: begin
        {hi_next, lo_next} = neg_hi ? -acc : acc;
        state_next = S_IDLE;
      end
      S_FIX_DIV: begin
        hi_next    = neg_hi ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];
        lo_next    = neg_lo ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (advance && bus.i_mdu_op == MDU_MTHI) hi_next = rs_data;
    if (advance && bus.i_mdu_op == MDU_MTLO) lo_next = rs_data;
`ifdef EXECUTION_FAST_MUL_EN
    if (advance && op_mul) {hi_next, lo_next} = fast_prod;
`endif
  end

  // MDU state register; iteration runs regardless of i_clk_en
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      acc    <= acc_next;
      opnd   <= opnd_next;
      neg_hi <= neg_hi_next;
      neg_lo <= neg_lo_next;
      hi     <= hi_next;
      lo     <= lo_next;
      busy_q <= (state_next != S_IDLE);
    end
  end

  // EX/MA register; a stall inserts a bubble and keeps the data fields
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctl_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      wdata_q  <= '0;
    end else if (bus.i_clk_en) begin
      if (stall) begin
        ctl_q <= '0;
        rd_q  <= '0;
      end else begin
        ctl_q    <= {ctl_ma_wb[NB_CONTROL_MA_WB-1:1], reg_write};
        rd_q     <= dest_num;
        result_q <= ex_result;
        wdata_q  <= rt_data;
      end
    end
  end

  assign bus.o_control_ma_wb    = ctl_q;
  assign bus.o_result           = result_q;
  assign bus.o_w_data_mem       = wdata_q;
  assign bus.o_rd_num           = rd_q;
  assign bus.o_mdu_busy         = busy_q;
  assign bus.o_stall            = stall;
  assign bus.o_id_rd_num        = dest_num;
  assign bus.o_id_ctl_mem_read  = ctl_ma_wb[NB_CONTROL_MA_WB-1];
  assign bus.o_id_ctl_reg_write = reg_write;
  assign bus.o_id_alu_result    = ex_result;
endmodule

// File: tb/tb_execution_mdu.sv
// Directed bench for execution_mdu: forwarding, destination select, MDU latency and HI/LO.
module tb_execution_mdu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;

  localparam logic [11:0] C_REG_DEST = 12'h800, C_RS_SA = 12'h400, C_RT_IMM = 12'h200,
                          C_USE_PC   = 12'h100, C_RD31  = 12'h080, C_MEMRD  = 12'h040,
                          C_RW       = 12'h001;
  localparam logic [5:0]  A_SLL = 6'h00, A_ADD = 6'h20, A_OR = 6'h25;
  localparam logic [3:0]  M_NONE = 4'd0, M_MULT = 4'd1, M_DIV = 4'd3, M_DIVU = 4'd4,
                          M_MFHI = 4'd5, M_MFLO = 4'd6, M_MTHI = 4'd7;
`ifdef EXECUTION_FAST_MUL_EN
  localparam int   MUL_STALL = 0;
  localparam logic MUL_BUSY  = 1'b0;
`else
  localparam int   MUL_STALL = 33;
  localparam logic MUL_BUSY  = 1'b1;
`endif

  execution_mdu_if u_if ();
  execution_mdu u_dut (.i_clk(clk), .i_reset(rst), .bus(u_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    u_if.i_clk_en        = 1'b1;
    u_if.i_control_bus   = '0;
    u_if.i_bus_a         = '0;
    u_if.i_bus_b         = '0;
    u_if.i_ext_literal   = '0;
    u_if.i_ext_sa        = '0;
    u_if.i_pc_delay_slot = '0;
    u_if.i_alu_op        = A_ADD;
    u_if.i_mdu_op        = M_NONE;
    u_if.i_id_rs_num     = '0;
    u_if.i_id_rt_num     = '0;
    u_if.i_id_rd_num     = '0;
    u_if.i_ma_rd_data    = '0;
    u_if.i_ma_rd_num     = '0;
    u_if.i_ma_ctl_rw     = 1'b0;
    u_if.i_wb_rd_data    = '0;
    u_if.i_wb_rd_num     = '0;
    u_if.i_wb_ctl_rw     = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear();
    step();
    step();
    check("rst_result", u_if.o_result, 32'h0);
    check("rst_rd", u_if.o_rd_num, 32'h0);
    check("rst_ctl", u_if.o_control_ma_wb, 32'h0);
    check("rst_busy", u_if.o_mdu_busy, 32'h0);
    check("rst_stall", u_if.o_stall, 32'h0);
    rst = 1'b0;

    // MA wins over WB
    clear();
    u_if.i_control_bus = C_REG_DEST | C_RW;
    u_if.i_id_rs_num = 5'd3; u_if.i_id_rd_num = 5'd5; u_if.i_bus_a = 32'h1000;
    u_if.i_ma_rd_num = 5'd3; u_if.i_ma_ctl_rw = 1'b1; u_if.i_ma_rd_data = 32'h11;
    u_if.i_wb_rd_num = 5'd3; u_if.i_wb_ctl_rw = 1'b1; u_if.i_wb_rd_data = 32'h22;
    #1 check("fwd_ma_comb", u_if.o_id_alu_result, 32'h11);
    step();
    check("fwd_ma_result", u_if.o_result, 32'h11);
    check("fwd_ma_rd", u_if.o_rd_num, 32'd5);
    check("fwd_ma_ctl", u_if.o_control_ma_wb, 32'h01);
    // WB when MA targets another register
    u_if.i_ma_rd_num = 5'd4;
    step();
    check("fwd_wb_result", u_if.o_result, 32'h22);
    // register 0 never forwards; dest 0 clears reg_write
    u_if.i_id_rs_num = '0; u_if.i_id_rd_num = '0; u_if.i_ma_rd_num = '0; u_if.i_wb_rd_num = '0;
    step();
    check("fwd_zero_result", u_if.o_result, 32'h1000);
    check("dest0_ctl", u_if.o_control_ma_wb, 32'h0);

    // JAL
    clear();
    u_if.i_control_bus = C_USE_PC | C_RD31 | C_RT_IMM | C_RW;
    u_if.i_pc_delay_slot = 32'h40; u_if.i_bus_a = 32'h999;
    #1 check("jal_id_rd", u_if.o_id_rd_num, 32'd31);
    check("jal_id_rw", u_if.o_id_ctl_reg_write, 32'd1);
    step();
    check("jal_result", u_if.o_result, 32'h40);
    check("jal_rd", u_if.o_rd_num, 32'd31);

    // ORI-style, rt destination, mem_read passthrough, store data
    clear();
    u_if.i_control_bus = C_RT_IMM | C_RW | C_MEMRD; u_if.i_alu_op = A_OR;
    u_if.i_bus_a = 32'hF0; u_if.i_ext_literal = 32'h0F; u_if.i_bus_b = 32'h1234;
    u_if.i_id_rt_num = 5'd9; u_if.i_id_rd_num = 5'd12;
    #1 check("ori_id_memrd", u_if.o_id_ctl_mem_read, 32'd1);
    step();
    check("ori_result", u_if.o_result, 32'hFF);
    check("ori_rd", u_if.o_rd_num, 32'd9);
    check("ori_wdata", u_if.o_w_data_mem, 32'h1234);
    check("ori_ctl", u_if.o_control_ma_wb, 32'h41);

    // SLL by shamt
    clear();
    u_if.i_control_bus = C_REG_DEST | C_RS_SA | C_RW; u_if.i_alu_op = A_SLL;
    u_if.i_ext_sa = 32'd4; u_if.i_bus_b = 32'h3; u_if.i_id_rt_num = 5'd2; u_if.i_id_rd_num = 5'd6;
    step();
    check("sll_result", u_if.o_result, 32'h30);
    // clock enable low holds outputs
    u_if.i_ext_sa = 32'd8; u_if.i_clk_en = 1'b0;
    step();
    check("clken_hold", u_if.o_result, 32'h30);

    // MULT -3 * 7, then MFLO stalls until the product lands
    clear();
    u_if.i_control_bus = C_REG_DEST | C_RW; u_if.i_mdu_op = M_MULT;
    u_if.i_id_rs_num = 5'd1; u_if.i_id_rt_num = 5'd2; u_if.i_id_rd_num = 5'd8;
    u_if.i_bus_a = 32'hFFFF_FFFD; u_if.i_bus_b = 32'd7;
    step();
    check("mult_ctl", u_if.o_control_ma_wb, 32'h0);
    check("mult_rd", u_if.o_rd_num, 32'd8);
    check("mult_busy", u_if.o_mdu_busy, 32'(MUL_BUSY));
    clear();
    u_if.i_control_bus = C_REG_DEST | C_RW; u_if.i_mdu_op = M_MFLO; u_if.i_id_rd_num = 5'd10;
    #1 n = 0;
    while (u_if.o_stall && n < 60) begin
      step();
      n++;
      if (n == 1) check("stall_bubble_rd", u_if.o_rd_num, 32'h0);
    end
    check("mult_stall_cycles", n, MUL_STALL);
    check("mflo_comb", u_if.o_id_alu_result, 32'hFFFF_FFEB);
    step();
    check("mflo_result", u_if.o_result, 32'hFFFF_FFEB);
    check("mflo_rd", u_if.o_rd_num, 32'd10);
    u_if.i_mdu_op = M_MFHI;
    step();
    check("mfhi_result", u_if.o_result, 32'hFFFF_FFFF);

    // DIV -7 / 2; non-MDU ops proceed while busy
    clear();
    u_if.i_mdu_op = M_DIV; u_if.i_id_rs_num = 5'd1; u_if.i_id_rt_num = 5'd2;
    u_if.i_bus_a = 32'hFFFF_FFF9; u_if.i_bus_b = 32'd2;
    step();
    clear();
    #1 check("nonmdu_no_stall", u_if.o_stall, 32'h0);
    n = 0;
    while (u_if.o_mdu_busy && n < 60) begin step(); n++; end
    check("div_done", u_if.o_mdu_busy, 32'h0);
    u_if.i_mdu_op = M_MFLO;
    #1 check("div_lo", u_if.o_id_alu_result, 32'hFFFF_FFFD);
    u_if.i_mdu_op = M_MFHI;
    #1 check("div_hi", u_if.o_id_alu_result, 32'hFFFF_FFFF);

    // DIVU 7 / 0
    clear();
    u_if.i_mdu_op = M_DIVU; u_if.i_bus_a = 32'd7; u_if.i_bus_b = 32'd0;
    step();
    clear();
    n = 0;
    while (u_if.o_mdu_busy && n < 60) begin step(); n++; end
    check("divz_done", u_if.o_mdu_busy, 32'h0);
    u_if.i_mdu_op = M_MFHI;
    #1 check("divz_hi", u_if.o_id_alu_result, 32'd7);
    u_if.i_mdu_op = M_MFLO;
    #1 check("divz_lo", u_if.o_id_alu_result, 32'hFFFF_FFFF);

    // reset part-way through a divide
    clear();
    u_if.i_mdu_op = M_DIV; u_if.i_bus_a = 32'd100; u_if.i_bus_b = 32'd3;
    step();
    clear();
    repeat (9) step();
    check("div_busy_before_rst", u_if.o_mdu_busy, 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_busy", u_if.o_mdu_busy, 32'h0);
    rst = 1'b0;
    u_if.i_mdu_op = M_MFHI;
    #1 check("rst_mid_stall", u_if.o_stall, 32'h0);
    check("rst_mid_hi", u_if.o_id_alu_result, 32'h0);
    step();
    check("rst_mid_result", u_if.o_result, 32'h0);

    // MTHI waits for the divide, then overwrites its remainder
    clear();
    u_if.i_mdu_op = M_DIV; u_if.i_bus_a = 32'd100; u_if.i_bus_b = 32'd3;
    step();
    clear();
    u_if.i_mdu_op = M_MTHI; u_if.i_id_rs_num = 5'd4; u_if.i_bus_a = 32'hAA;
    #1 check("mthi_stall", u_if.o_stall, 32'd1);
    n = 0;
    while (u_if.o_stall && n < 60) begin step(); n++; end
    check("mthi_stall_end", u_if.o_stall, 32'h0);
    step();
    clear();
    u_if.i_mdu_op = M_MFHI;
    #1 check("mthi_hi", u_if.o_id_alu_result, 32'hAA);
    u_if.i_mdu_op = M_MFLO;
    #1 check("mthi_lo", u_if.o_id_alu_result, 32'h21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
